// File: rtl/modp_pkg.sv
// Shared types and error codes for the modular key engine.
package modp_pkg;

    typedef enum logic [1:0] {
        KEYGEN   = 2'b00,
        ENCRYPT  = 2'b01,
        DECRYPT  = 2'b10,
        RESERVED = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        REDUCE,
        DONE
    } state_e;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_NOKEY = 2'b10;
    localparam logic [1:0] ERR_MODE  = 2'b11;

endpackage

// File: rtl/modp_addsub.sv
// Two-stage modular add/subtract datapath: raw sum/biased difference, then reduce.
module modp_addsub #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         add_en,
    input  logic         red_en,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic [W-1:0] red_next,
    output logic [W-1:0] red_q
);

    logic [W:0]   raw_q;
    logic [W:0]   raw_d;
    logic [W-1:0] red_d;

    // Stage 1: a+b, or a-b+P so the difference never goes negative
    always_comb begin
        raw_d = raw_q;
        if (add_en) begin
            if (sub) begin
                raw_d = {1'b0, a} - {1'b0, b} + {1'b0, p};
            end else begin
                raw_d = {1'b0, a} + {1'b0, b};
            end
        end
    end

    // Stage 2: operands are below P, so raw < 2P and one conditional subtract reduces it
    always_comb begin
        if (raw_q >= {1'b0, p}) begin
            red_next = raw_q[W-1:0] - p;
        end else begin
            red_next = raw_q[W-1:0];
        end
        red_d = red_en ? red_next : red_q;
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            raw_q <= '0;
            red_q <= '0;
        end else begin
            raw_q <= raw_d;
            red_q <= red_d;
        end
    end

endmodule

// File: rtl/modp_key_engine.sv
// Modular key engine: keygen, encrypt and decrypt mod P with a fixed-latency handshake.
module modp_key_engine #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] p_par,
    input  logic [W-1:0] q_par,
    input  logic [W-1:0] secret_key,
    input  logic [W-1:0] data_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [W-1:0] result,
    output logic [W-1:0] public_key,
    output logic         pk_valid
);
    import modp_pkg::*;

    state_e       state_q, state_d;
    mode_e        mode_q, mode_d;
    logic [W-1:0] p_in_q, p_in_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] sk_q, sk_d;
    logic [W-1:0] din_q, din_d;
    logic [W-1:0] p_st_q, p_st_d;
    logic [W-1:0] pk_q, pk_d;
    logic         pk_valid_q, pk_valid_d;
    logic         err_q, err_d;
    logic [1:0]   err_code_q, err_code_d;

    logic [1:0]   chk_code;
    logic [W:0]   sk_plus2;
    logic         add_en, red_en, is_keygen;
    logic [W-1:0] op_a, op_b, op_p;
    logic [W-1:0] red_next;

    // Operand validation against the latched request and the key store
    always_comb begin
        chk_code = ERR_OK;
        sk_plus2 = {1'b0, sk_q} + (W+1)'(2);
        case (mode_q)
            KEYGEN: begin
                if (p_in_q < W'(3) || sk_q == '0 || sk_plus2 > {1'b0, p_in_q} ||
                    q_q == '0 || q_q >= p_in_q) begin
                    chk_code = ERR_RANGE;
                end
            end
            ENCRYPT, DECRYPT: begin
                if (!pk_valid_q) begin
                    chk_code = ERR_NOKEY;
                end else if (din_q >= p_st_q) begin
                    chk_code = ERR_RANGE;
                end
            end
            default: chk_code = ERR_MODE;
        endcase
    end

    // Operand selection: keygen uses the request's P, the others use the stored key
    always_comb begin
        is_keygen = (mode_q == KEYGEN);
        op_a      = is_keygen ? sk_q : din_q;
        op_b      = is_keygen ? q_q : pk_q;
        op_p      = is_keygen ? p_in_q : p_st_q;
    end

    // FSM next state, request latching, key store and error updates
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        p_in_d     = p_in_q;
        q_d        = q_q;
        sk_d       = sk_q;
        din_d      = din_q;
        p_st_d     = p_st_q;
        pk_d       = pk_q;
        pk_valid_d = pk_valid_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        add_en     = 1'b0;
        red_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode_e'(mode);
                    p_in_d     = p_par;
                    q_d        = q_par;
                    sk_d       = secret_key;
                    din_d      = data_in;
                    err_d      = 1'b0;
                    err_code_d = ERR_OK;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (chk_code != ERR_OK) begin
                    err_d      = 1'b1;
                    err_code_d = chk_code;
                    state_d    = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                add_en  = 1'b1;
                state_d = REDUCE;
            end
            REDUCE: begin
                red_en  = 1'b1;
                state_d = DONE;
                if (is_keygen) begin
                    pk_d       = red_next;
                    p_st_d     = p_in_q;
                    pk_valid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            mode_q     <= KEYGEN;
            p_in_q     <= '0;
            q_q        <= '0;
            sk_q       <= '0;
            din_q      <= '0;
            p_st_q     <= '0;
            pk_q       <= '0;
            pk_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OK;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            p_in_q     <= p_in_d;
            q_q        <= q_d;
            sk_q       <= sk_d;
            din_q      <= din_d;
            p_st_q     <= p_st_d;
            pk_q       <= pk_d;
            pk_valid_q <= pk_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    modp_addsub #(
        .W(W)
    ) u_addsub (
        .clk     (clk),
        .rst_n   (rst_n),
        .add_en  (add_en),
        .red_en  (red_en),
        .sub     (mode_q == DECRYPT),
        .a       (op_a),
        .b       (op_b),
        .p       (op_p),
        .red_next(red_next),
        .red_q   (result)
    );

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign public_key = pk_q;
    assign pk_valid   = pk_valid_q;

endmodule

// File: tb/tb_modp_key_engine.sv
// Bench for modp_key_engine: W=8 and W=16 instances against an arithmetic reference model.
module tb_modp_key_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] p_v = '0, q_v = '0, sk_v = '0, din_v = '0;

    logic        busy8, done8, err8, pkv8;
    logic [1:0]  code8;
    logic [7:0]  res8, pk8;
    logic        busy16, done16, err16, pkv16;
    logic [1:0]  code16;
    logic [15:0] res16, pk16;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    modp_key_engine #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode),
        .p_par(p_v[7:0]), .q_par(q_v[7:0]), .secret_key(sk_v[7:0]), .data_in(din_v[7:0]),
        .busy(busy8), .done(done8), .err(err8), .err_code(code8),
        .result(res8), .public_key(pk8), .pk_valid(pkv8)
    );

    modp_key_engine #(.W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode),
        .p_par(p_v[15:0]), .q_par(q_v[15:0]), .secret_key(sk_v[15:0]), .data_in(din_v[15:0]),
        .busy(busy16), .done(done16), .err(err16), .err_code(code16),
        .result(res16), .public_key(pk16), .pk_valid(pkv16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed visible state, pending outcome, and op progress
    longint unsigned m_pk[2], m_ps[2], m_res[2], n_pk[2], n_ps[2], n_res[2];
    bit              m_pkv[2], m_err[2], n_pkv[2];
    int              m_code[2], n_code[2];
    bit              m_act[2];
    int              m_cyc[2], m_len[2];

    task automatic model_edge(input int i, input logic st);
        longint unsigned mask, p, q, sk, d, r;
        int code;
        mask = (i == 0) ? 64'hFF : 64'hFFFF;
        if (rst_n) begin
            m_pk[i] = 0; m_ps[i] = 0; m_res[i] = 0; m_pkv[i] = 0;
            m_err[i] = 0; m_code[i] = 0; m_act[i] = 0; m_cyc[i] = 0; m_len[i] = 0;
        end else if (m_act[i]) begin
            m_cyc[i]++;
            if (m_cyc[i] == m_len[i] - 1) begin
                m_err[i]  = (n_code[i] != 0);
                m_code[i] = n_code[i];
                m_res[i]  = n_res[i];
                m_pk[i]   = n_pk[i];
                m_ps[i]   = n_ps[i];
                m_pkv[i]  = n_pkv[i];
            end
            if (m_cyc[i] == m_len[i]) m_act[i] = 0;
        end else if (st) begin
            p = longint'(p_v) & mask;
            q = longint'(q_v) & mask;
            sk = longint'(sk_v) & mask;
            d = longint'(din_v) & mask;
            code = 0;
            r = 0;
            if (mode == 2'b11) code = 3;
            else if (mode == 2'b00) begin
                if (p < 3 || sk == 0 || sk > p - 2 || q == 0 || q >= p) code = 1;
                else r = (sk + q) % p;
            end else if (!m_pkv[i]) code = 2;
            else if (d >= m_ps[i]) code = 1;
            else if (mode == 2'b01) r = (d + m_pk[i]) % m_ps[i];
            else r = (d + m_ps[i] - m_pk[i]) % m_ps[i];
            n_code[i] = code;
            n_res[i]  = (code != 0) ? m_res[i] : r;
            n_pk[i]   = m_pk[i];
            n_ps[i]   = m_ps[i];
            n_pkv[i]  = m_pkv[i];
            if (code == 0 && mode == 2'b00) begin
                n_pk[i] = r; n_ps[i] = p; n_pkv[i] = 1;
            end
            m_err[i]  = 0;
            m_code[i] = 0;
            m_act[i]  = 1;
            m_cyc[i]  = 0;
            m_len[i]  = (code != 0) ? 2 : 4;
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, start8);
        model_edge(1, start16);
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), (i == 0) ? busy8 : busy16, m_act[i]);
                chk($sformatf("done[%0d]", i), (i == 0) ? done8 : done16,
                    m_act[i] && (m_cyc[i] == m_len[i] - 1));
                chk($sformatf("err[%0d]", i), (i == 0) ? err8 : err16, m_err[i]);
                chk($sformatf("err_code[%0d]", i), (i == 0) ? code8 : code16, m_code[i]);
                chk($sformatf("result[%0d]", i), (i == 0) ? 64'(res8) : 64'(res16), m_res[i]);
                chk($sformatf("public_key[%0d]", i), (i == 0) ? 64'(pk8) : 64'(pk16), m_pk[i]);
                chk($sformatf("pk_valid[%0d]", i), (i == 0) ? pkv8 : pkv16, m_pkv[i]);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Issue one request; lat is the cycle index of done, nbusy the busy cycles seen
    task automatic run_op(input int i, input logic [1:0] md, input int p, input int q,
                          input int sk, input int d, input int hold,
                          output int lat, output int nbusy);
        @(negedge clk);
        mode = md; p_v = p; q_v = q; sk_v = sk; din_v = d;
        if (i == 0) start8 = 1'b1; else start16 = 1'b1;
        lat = -1;
        nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= hold) begin start8 = 1'b0; start16 = 1'b0; end
            if ((i == 0) ? busy8 : busy16) nbusy++;
            if ((i == 0) ? done8 : done16) begin
                start8 = 1'b0; start16 = 1'b0;
                lat = k;
                break;
            end
        end
        start8 = 1'b0; start16 = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 12 cycles");
        end
    endtask

    initial begin
        int lat, nb, ndone, i, md, p, ps;
        do_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_result", res8, 0);
        chk("reset_pk_valid", pkv8, 0);

        // W=8 directed sequence
        run_op(0, 2'b00, 227, 200, 100, 0, 1, lat, nb);
        chk("kg_lat", lat, 3); chk("kg_busy", nb, 4);
        chk("kg_result", res8, 73); chk("kg_pk", pk8, 73); chk("kg_pkv", pkv8, 1);
        chk("kg_err", err8, 0);
        run_op(0, 2'b01, 0, 0, 0, 200, 1, lat, nb);
        chk("enc_lat", lat, 3); chk("enc_busy", nb, 4); chk("enc_result", res8, 46);
        run_op(0, 2'b10, 0, 0, 0, 46, 1, lat, nb);
        chk("dec_lat", lat, 3); chk("dec_busy", nb, 4); chk("dec_result", res8, 200);
        run_op(0, 2'b00, 227, 226, 225, 0, 1, lat, nb);
        chk("kg_edge_result", res8, 224); chk("kg_edge_pk", pk8, 224);
        run_op(0, 2'b00, 227, 226, 226, 0, 1, lat, nb);
        chk("kg_bad_lat", lat, 1); chk("kg_bad_err", err8, 1); chk("kg_bad_code", code8, 1);
        chk("kg_bad_pk_kept", pk8, 224);

        do_reset();
        run_op(0, 2'b01, 0, 0, 0, 5, 1, lat, nb);
        chk("nokey_lat", lat, 1); chk("nokey_code", code8, 2);
        run_op(0, 2'b11, 0, 0, 0, 0, 1, lat, nb);
        chk("mode_code", code8, 3); chk("mode_err", err8, 1);

        // start held through busy: one done only
        run_op(0, 2'b00, 227, 200, 100, 0, 3, lat, nb);
        chk("hold_lat", lat, 3);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("hold_extra_done", ndone, 0);

        // reset during ADD of an encrypt
        @(negedge clk);
        mode = 2'b01; din_v = 200; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        chk("abort_in_add_busy", busy8, 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("abort_busy", busy8, 0); chk("abort_done", done8, 0);
        chk("abort_pkv", pkv8, 0); chk("abort_result", res8, 0); chk("abort_pk", pk8, 0);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // W=16 directed sequence
        run_op(1, 2'b00, 65521, 65520, 65519, 0, 1, lat, nb);
        chk("kg16_result", res16, 65518); chk("kg16_pkv", pkv16, 1);
        run_op(1, 2'b01, 0, 0, 0, 65520, 1, lat, nb);
        chk("enc16_result", res16, 65517);
        run_op(1, 2'b10, 0, 0, 0, 65517, 1, lat, nb);
        chk("dec16_result", res16, 65520);

        // Randomised traffic on both widths; the model checks every cycle
        for (int n = 0; n < 300; n++) begin
            i = $urandom_range(1, 0);
            md = $urandom_range(9, 0);
            ps = int'(m_ps[i]);
            if (md < 3) begin
                p = $urandom_range((i == 0) ? 255 : 65535, 3);
                if ($urandom_range(7, 0) == 0)
                    run_op(i, 2'b00, $urandom, $urandom, $urandom, 0, 1, lat, nb);
                else
                    run_op(i, 2'b00, p, $urandom_range(p - 1, 1), $urandom_range(p - 2, 1), 0,
                           1, lat, nb);
            end else if (md < 9) begin
                if (ps > 0 && $urandom_range(7, 0) != 0)
                    run_op(i, (md < 6) ? 2'b01 : 2'b10, 0, 0, 0, $urandom_range(ps - 1, 0), 1,
                           lat, nb);
                else
                    run_op(i, (md < 6) ? 2'b01 : 2'b10, 0, 0, 0, $urandom, 1, lat, nb);
            end else begin
                run_op(i, 2'b11, $urandom, $urandom, $urandom, $urandom, 1, lat, nb);
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
